// File: rtl/pipeline_arbiter_if.sv
// Bundles the requester, pipeline and response signals of pipeline_arbiter.
// The slave modport is the arbiter view; master is the view of the surrounding logic.
interface pipeline_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int PIPELINE_LENGTH = 16
);
    localparam int CNT_W = $clog2(PIPELINE_LENGTH + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_enable;
    logic [DATA_WIDTH-1:0]         pipe_data;
    logic                          pipe_valid;
    logic [DATA_WIDTH-1:0]         pipe_out_data;
    logic                          pipe_out_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [CNT_W-1:0]              in_flight;
    logic                          err_underflow;

    modport slave (
        input  req_valid, req_data, req_enable, pipe_out_data, pipe_out_valid,
        output req_ready, pipe_data, pipe_valid, rsp_data, rsp_valid, in_flight, err_underflow
    );

    modport master (
        output req_valid, req_data, req_enable, pipe_out_data, pipe_out_valid,
        input  req_ready, pipe_data, pipe_valid, rsp_data, rsp_valid, in_flight, err_underflow
    );
endinterface

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipeline between NUM_REQ requesters,
// with an in-order tag FIFO that routes each returning beat back to its issuer.
module pipeline_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int PIPELINE_LENGTH = 16
) (
    input logic               clk,
    input logic               rst,
    pipeline_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(PIPELINE_LENGTH);
    localparam int CNT_W = $clog2(PIPELINE_LENGTH + 1);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      in_flight_q, in_flight_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  err_underflow_q, err_underflow_d;
    logic [ID_W-1:0]       tag_mem_q [PIPELINE_LENGTH];

    logic [NUM_REQ-1:0]    eligible;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       cand;
    logic                  push;
    logic                  pop;
    logic                  underflow;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PIPELINE_LENGTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        eligible = bus.req_valid & bus.req_enable;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end

        grant_id = ptr_q;
        cand     = ptr_q;
        // Scan from farthest to nearest so the first eligible requester after ptr_q is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (eligible[cand]) grant_id = cand;
        end

        // NOTE: the cap looks at the registered count, so a slot freed by this cycle's pop is grantable next cycle.
        push = !rst && (eligible != '0) && (in_flight_q < CNT_W'(PIPELINE_LENGTH));

        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = push && (ID_W'(i) == grant_id);
        end

        pop       = bus.pipe_out_valid && (in_flight_q != '0);
        underflow = bus.pipe_out_valid && (in_flight_q == '0);
    end

    always_comb begin
        ptr_d           = push ? grant_id : ptr_q;
        wr_ptr_d        = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d        = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        pipe_valid_d    = push;
        pipe_data_d     = push ? req_word[grant_id] : pipe_data_q;
        rsp_data_d      = pop ? bus.pipe_out_data : rsp_data_q;
        err_underflow_d = err_underflow_q | underflow;

        in_flight_d = in_flight_q;
        if (push && !pop) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (pop && !push) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = pop && (tag_mem_q[rd_ptr_q] == ID_W'(i));
        end
    end

    // NOTE: reset is synchronous and sampled inside the clocked block; state updates are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q           <= ID_W'(NUM_REQ - 1);
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            in_flight_q     <= '0;
            pipe_valid_q    <= 1'b0;
            pipe_data_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            in_flight_q     <= in_flight_d;
            pipe_valid_q    <= pipe_valid_d;
            pipe_data_q     <= pipe_data_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // NOTE: tag storage is not reset; the pointers and in_flight alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_id;
    end

    assign bus.pipe_valid    = pipe_valid_q;
    assign bus.pipe_data     = pipe_data_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.in_flight     = in_flight_q;
    assign bus.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Randomized bench for pipeline_arbiter: an elastic pass-through pipeline model, a
// round-robin reference model, and a scoreboard drained by an independent response monitor.
module tb_pipeline_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int PL = 16;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PIPELINE_LENGTH(PL)) bus ();

    pipeline_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PIPELINE_LENGTH(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rsp_t  sb[$];
    beat_t pq[$];

    logic          stall       = 1'b0;
    logic          inject      = 1'b0;
    logic [DW-1:0] inject_data = '0;

    int            m_last     = NR - 1;
    int            m_inflight = 0;
    logic          m_pv       = 1'b0;
    logic          m_rsp      = 1'b0;
    logic          m_err      = 1'b0;
    logic [DW-1:0] m_pd       = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_last     = NR - 1;
        m_inflight = 0;
        m_pv       = 1'b0;
        m_pd       = '0;
        m_err      = 1'b0;
        m_rsp      = 1'b0;
        sb.delete();
        pq.delete();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
    endtask

    // One clock cycle: drive the pipeline output, check and predict at negedge, advance at posedge.
    task automatic cycle();
        logic [NR-1:0] e;
        logic [DW-1:0] wd;
        logic          pov;
        logic          from_pipe;
        logic          popped;
        int            w;
        int            idx;
        beat_t         b;
        rsp_t          r;

        pov               = 1'b0;
        from_pipe         = 1'b0;
        bus.pipe_out_data = DW'($urandom);
        if (inject) begin
            pov               = 1'b1;
            bus.pipe_out_data = inject_data;
        end else if (!stall && pq.size() > 0 && pq[0].rdy <= cyc) begin
            pov               = 1'b1;
            from_pipe         = 1'b1;
            bus.pipe_out_data = pq[0].data;
        end
        bus.pipe_out_valid = pov;

        @(negedge clk);
        if (rst) begin
            check("ready_in_reset", int'(bus.req_ready), 0);
        end else begin
            check("in_flight", int'(bus.in_flight), m_inflight);
            check("err_underflow", int'(bus.err_underflow), int'(m_err));
            check("pipe_valid", int'(bus.pipe_valid), int'(m_pv));
            check("pipe_data", int'(bus.pipe_data), int'(m_pd));
            check("rsp_present", int'(bus.rsp_valid != '0), int'(m_rsp));

            e = bus.req_valid & bus.req_enable;
            w = -1;
            if (e != '0 && m_inflight < PL) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_last + k) % NR;
                    if (w < 0 && ((int'(e) >> idx) & 1) == 1) w = idx;
                end
            end
            check("req_ready", int'(bus.req_ready), (w >= 0) ? (1 << w) : 0);

            if (w >= 0) begin
                wd     = DW'(bus.req_data >> (w * DW));
                r.id   = w;
                r.data = wd;
                sb.push_back(r);
                m_last = w;
                m_pv   = 1'b1;
                m_pd   = wd;
            end else begin
                m_pv = 1'b0;
            end
            popped     = pov && (m_inflight > 0);
            if (pov && m_inflight == 0) m_err = 1'b1;
            m_rsp      = popped;
            m_inflight = m_inflight + ((w >= 0) ? 1 : 0) - (popped ? 1 : 0);
        end

        if (bus.pipe_valid) begin
            b.data = bus.pipe_data;
            b.rdy  = cyc + PL;
            pq.push_back(b);
        end
        if (from_pipe) pq.delete(0);

        @(posedge clk);
        if (rst) model_reset();
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n;
        n             = 0;
        bus.req_valid = '0;
        stall         = 1'b0;
        inject        = 1'b0;
        while ((sb.size() != 0 || m_inflight != 0 || pq.size() != 0) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_complete", int'(sb.size()) + m_inflight + int'(pq.size()), 0);
        repeat (2) cycle();
    endtask

    always @(negedge clk) begin : monitor
        rsp_t r;
        if (!rst && bus.rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", int'(bus.rsp_valid), 0);
            end else begin
                r = sb.pop_front();
                check("rsp_owner", int'(bus.rsp_valid), 1 << r.id);
                check("rsp_data", int'(bus.rsp_data), int'(r.data));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time budget expired at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.req_valid      = '0;
        bus.req_enable     = '1;
        bus.req_data       = '0;
        bus.pipe_out_valid = 1'b0;
        bus.pipe_out_data  = '0;

        rst = 1'b1;
        repeat (20) begin
            bus.req_valid = NR'($urandom);
            cycle();
        end
        rst           = 1'b0;
        bus.req_valid = '0;
        cycle();

        // Single beat from requester 2.
        bus.req_valid            = 4'b0100;
        bus.req_data[2*DW +: DW] = 8'hDB;
        cycle();
        drain();

        // All four requesters continuously valid.
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = DW'(8'h10 + i);
        bus.req_valid = '1;
        repeat (40) cycle();
        drain();

        // Fill to the cap with the pipeline output stalled, then release a single pop.
        bus.req_valid = 4'b0001;
        stall         = 1'b1;
        repeat (30) begin
            rand_data();
            cycle();
        end
        check("fill_cap_in_flight", int'(bus.in_flight), PL);
        check("fill_cap_ready", int'(bus.req_ready), 0);
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        repeat (5) cycle();
        drain();

        // Masking: only 1 and 3 enabled, then only 1.
        bus.req_valid  = '1;
        bus.req_enable = 4'b1010;
        repeat (12) begin
            rand_data();
            cycle();
        end
        bus.req_enable = 4'b0010;
        repeat (8) begin
            rand_data();
            cycle();
        end
        bus.req_enable = '1;
        drain();

        // Underflow: pipeline output with nothing outstanding.
        inject      = 1'b1;
        inject_data = DW'($urandom);
        cycle();
        inject = 1'b0;
        repeat (5) cycle();

        // Randomized traffic with random masks and occasional output stalls.
        repeat (300) begin
            bus.req_valid  = NR'($urandom);
            bus.req_enable = NR'($urandom);
            stall          = ($urandom_range(0, 7) == 0);
            rand_data();
            cycle();
        end
        bus.req_enable = '1;
        drain();

        // Reset with five beats outstanding.
        repeat (5) begin
            bus.req_valid = NR'($urandom_range(1, 15));
            rand_data();
            cycle();
        end
        bus.req_valid = '0;
        repeat (3) cycle();
        check("in_flight_before_reset", int'(bus.in_flight), 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rsp_data_after_reset", int'(bus.rsp_data), 0);
        check("rsp_valid_after_reset", int'(bus.rsp_valid), 0);
        bus.req_valid = 4'b1001;
        rand_data();
        cycle();
        bus.req_valid = 4'b1000;
        cycle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
